// File: rtl/maze_pkg.sv
// Shared encodings for the DFS maze solver: move directions, FSM states and
// the goal coordinate helper.
package maze_pkg;

    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_UP    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_MARK   = 3'd2,
        ST_PROBE  = 3'd3,
        ST_BACK   = 3'd4,
        ST_STREAM = 3'd5,
        ST_DONE   = 3'd6,
        ST_FAIL   = 3'd7
    } state_e;

    // RIGHT<->LEFT and DOWN<->UP differ only in bit 1
    function automatic logic [1:0] opposite(input logic [1:0] d);
        return d ^ 2'd2;
    endfunction

    function automatic int unsigned goal_coord(input int unsigned n);
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/solver_stack.sv
// LIFO of 2-bit moves with a top-of-stack read and an indexed read port
// used to replay the path from the bottom.
module solver_stack #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [1:0]    push_data,
    input  logic [AW-1:0] rd_addr,
    output logic [AW:0]   sp,
    output logic [1:0]    top,
    output logic [1:0]    rd_data
);
    localparam int DEPTH = 1 << AW;

    logic [1:0]    mem_q [DEPTH];
    logic [AW:0]   sp_q, sp_d;
    logic [AW-1:0] top_idx_s;

    // Stack pointer next-state
    always_comb begin
        if (clr) begin
            sp_d = '0;
        end else if (push) begin
            sp_d = sp_q + (AW+1)'(1);
        end else if (pop) begin
            sp_d = sp_q - (AW+1)'(1);
        end else begin
            sp_d = sp_q;
        end
    end

    // Stack pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sp_q <= '0;
        else        sp_q <= sp_d;
    end

    // Storage array; contents above sp are don't-care so no reset needed
    always_ff @(posedge clk) begin
        if (push) mem_q[sp_q[AW-1:0]] <= push_data;
    end

    assign top_idx_s = sp_q[AW-1:0] - AW'(1);
    assign top       = mem_q[top_idx_s];
    assign rd_data   = mem_q[rd_addr];
    assign sp        = sp_q;

    solver_stack_chk #(.AW(AW)) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .sp    (sp_q)
    );

endmodule

// File: rtl/solver_stack_chk.sv
// Simulation checker for the direction stack: a push must never hit a full stack.
module solver_stack_chk #(
    parameter int AW = 8
) (
    input logic          clk,
    input logic          rst_n,
    input logic          push,
    input logic [AW:0]   sp
);
    localparam int DEPTH = 1 << AW;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (sp == (AW+1)'(DEPTH))));

endmodule

// File: rtl/maze_solver.sv
// DFS rat-in-maze controller driving an external 1-bit maze memory; searches
// (0,0) -> (2**N-1, 2**N-1) and then streams the found path as moves.
module maze_solver
    import maze_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic [N-1:0] X,
    output logic [N-1:0] Y,
    output logic         D_in,
    output logic         RD,
    output logic         WR,
    input  logic         D_out,
    output logic         busy,
    output logic         done,
    output logic         fail,
    output logic         path_valid,
    output logic [1:0]   path_dir,
    output logic         path_last,
    input  logic         path_ready
);
    localparam int           AW   = 2 * N;
    localparam logic [N-1:0] GOAL = N'(goal_coord(N));
    localparam logic [N-1:0] ONE  = N'(1);

    state_e        state_q, state_d;
    logic [N-1:0]  cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [N-1:0]  x_q, x_d, y_q, y_d;
    logic [N-1:0]  nb_x_s, nb_y_s, bk_x_s, bk_y_s, pb_x_s, pb_y_s;
    logic [1:0]    dir_q, dir_d, pdir_q, pdir_d;
    logic [AW-1:0] rd_idx_q, rd_idx_d, rd_next_s, rd_addr_s;
    logic          rd_q, rd_d, wr_q, wr_d, din_q, din_d;
    logic          busy_q, busy_d, done_q, done_d, fail_q, fail_d;
    logic          pv_q, pv_d, plast_q, plast_d;
    logic          push_s, pop_s, clr_s;
    logic [1:0]    top_s, rd_data_s;
    logic [AW:0]   sp_s;

    function automatic logic nb_ok(input logic [N-1:0] x, input logic [N-1:0] y,
                                   input logic [1:0] d);
        case (d)
            DIR_RIGHT: return y != GOAL;
            DIR_DOWN:  return x != GOAL;
            DIR_LEFT:  return y != '0;
            DIR_UP:    return x != '0;
            default:   return 1'b0;
        endcase
    endfunction

    function automatic logic [2*N-1:0] step(input logic [N-1:0] x, input logic [N-1:0] y,
                                            input logic [1:0] d);
        case (d)
            DIR_RIGHT: return {x, y + ONE};
            DIR_DOWN:  return {x + ONE, y};
            DIR_LEFT:  return {x, y - ONE};
            DIR_UP:    return {x - ONE, y};
            default:   return {x, y};
        endcase
    endfunction

    // Search / stream sequencing
    always_comb begin
        state_d  = state_q;
        cur_x_d  = cur_x_q;
        cur_y_d  = cur_y_q;
        dir_d    = dir_q;
        rd_idx_d = rd_idx_q;
        busy_d   = busy_q;
        done_d   = done_q;
        fail_d   = fail_q;
        pv_d     = pv_q;
        pdir_d   = pdir_q;
        plast_d  = plast_q;
        push_s   = 1'b0;
        pop_s    = 1'b0;
        clr_s    = 1'b0;
        rd_next_s = rd_idx_q + AW'(1);
        rd_addr_s = (state_q == ST_STREAM) ? rd_next_s : '0;
        {nb_x_s, nb_y_s} = step(cur_x_q, cur_y_q, dir_q);
        {bk_x_s, bk_y_s} = step(cur_x_q, cur_y_q, opposite(top_s));
        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start) begin
                    state_d = ST_CHECK;
                    cur_x_d = '0;
                    cur_y_d = '0;
                    dir_d   = DIR_RIGHT;
                    clr_s   = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    fail_d  = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_CHECK: begin
                if (D_out) begin
                    state_d = ST_FAIL;
                    busy_d  = 1'b0;
                    fail_d  = 1'b1;
                end else begin
                    state_d = ST_MARK;
                end
            end
            ST_MARK: begin
                if (cur_x_q == GOAL && cur_y_q == GOAL) begin
                    state_d  = ST_STREAM;
                    rd_idx_d = '0;
                    pv_d     = 1'b1;
                    pdir_d   = rd_data_s;
                    plast_d  = (sp_s == (AW+1)'(1));
                end else begin
                    state_d = ST_PROBE;
                    dir_d   = DIR_RIGHT;
                end
            end
            ST_PROBE: begin
                // rd_q is high exactly when the probed neighbour lies inside the grid
                if (rd_q && !D_out) begin
                    push_s  = 1'b1;
                    cur_x_d = nb_x_s;
                    cur_y_d = nb_y_s;
                    state_d = ST_MARK;
                end else if (dir_q == DIR_UP) begin
                    if (sp_s == '0) begin
                        state_d = ST_FAIL;
                        busy_d  = 1'b0;
                        fail_d  = 1'b1;
                    end else begin
                        state_d = ST_BACK;
                    end
                end else begin
                    dir_d = dir_q + 2'd1;
                end
            end
            ST_BACK: begin
                pop_s   = 1'b1;
                cur_x_d = bk_x_s;
                cur_y_d = bk_y_s;
                if (top_s == DIR_UP) begin
                    if (sp_s == (AW+1)'(1)) begin
                        state_d = ST_FAIL;
                        busy_d  = 1'b0;
                        fail_d  = 1'b1;
                    end else begin
                        state_d = ST_BACK;
                    end
                end else begin
                    dir_d   = top_s + 2'd1;
                    state_d = ST_PROBE;
                end
            end
            ST_STREAM: begin
                if (pv_q && path_ready) begin
                    if (plast_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        pv_d    = 1'b0;
                        plast_d = 1'b0;
                    end else begin
                        rd_idx_d = rd_next_s;
                        pdir_d   = rd_data_s;
                        plast_d  = ({1'b0, rd_next_s} == sp_s - (AW+1)'(1));
                    end
                end else begin
                    state_d = ST_STREAM;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory strobes and address for the cycle being entered
    always_comb begin
        rd_d  = 1'b0;
        wr_d  = 1'b0;
        din_d = 1'b0;
        x_d   = x_q;
        y_d   = y_q;
        {pb_x_s, pb_y_s} = step(cur_x_d, cur_y_d, dir_d);
        case (state_d)
            ST_CHECK: begin
                rd_d = 1'b1;
                x_d  = cur_x_d;
                y_d  = cur_y_d;
            end
            ST_MARK: begin
                wr_d  = 1'b1;
                din_d = 1'b1;
                x_d   = cur_x_d;
                y_d   = cur_y_d;
            end
            ST_PROBE: begin
                if (nb_ok(cur_x_d, cur_y_d, dir_d)) begin
                    rd_d = 1'b1;
                    x_d  = pb_x_s;
                    y_d  = pb_y_s;
                end else begin
                    x_d = cur_x_d;
                    y_d = cur_y_d;
                end
            end
            default: begin
                x_d = x_q;
                y_d = y_q;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            dir_q    <= DIR_RIGHT;
            rd_idx_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            din_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
            pv_q     <= 1'b0;
            pdir_q   <= 2'd0;
            plast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            dir_q    <= dir_d;
            rd_idx_q <= rd_idx_d;
            x_q      <= x_d;
            y_q      <= y_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            din_q    <= din_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fail_q   <= fail_d;
            pv_q     <= pv_d;
            pdir_q   <= pdir_d;
            plast_q  <= plast_d;
        end
    end

    solver_stack #(.AW(AW)) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr_s),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (dir_q),
        .rd_addr   (rd_addr_s),
        .sp        (sp_s),
        .top       (top_s),
        .rd_data   (rd_data_s)
    );

    assign X          = x_q;
    assign Y          = y_q;
    assign RD         = rd_q;
    assign WR         = wr_q;
    assign D_in       = din_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fail       = fail_q;
    assign path_valid = pv_q;
    assign path_dir   = pdir_q;
    assign path_last  = plast_q;

endmodule
